// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller with a Wishbone register interface.
// Optional INTC_SYNC_EN adds a 2-flop synchroniser on irq_in.
module interrupt_controller #(
    parameter int NSRC = 16,
    parameter int VECW = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bus_cyc,
    input  logic              bus_stb,
    input  logic              bus_we,
    input  logic [2:0]        bus_adr,
    input  logic [31:0]       bus_dat_i,
    output logic [31:0]       bus_dat_o,
    output logic              bus_ack,
    input  logic [NSRC-1:0]   irq_in,
    input  logic              enabled,
    output logic              irq_valid,
    output logic [VECW-1:0]   cpu_exception
);

    typedef enum logic [2:0] {
        REG_PEND = 3'd0,
        REG_MASK = 3'd1,
        REG_CLR  = 3'd2,
        REG_MODE = 3'd3,
        REG_VEC  = 3'd4
    } reg_addr_e;

    logic [NSRC-1:0] src_in;
    logic [NSRC-1:0] samp_q, samp_d;
    logic [NSRC-1:0] prev_q, prev_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_o_q, dat_o_d;
    logic            irq_valid_q, irq_valid_d;
    logic [VECW-1:0] cpu_exception_q, cpu_exception_d;

    logic            access;
    logic            wr;
    logic [NSRC-1:0] clr_vec;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] act;
    logic [VECW-1:0] enc;
    logic [31:0]     rdata;
    logic            unused_dat;

    assign unused_dat = ^bus_dat_i;

`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync1_d;
    logic [NSRC-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = irq_in;
`endif

    // A new transfer is accepted only while ack is low, giving one transfer per two cycles.
    assign access = bus_cyc & bus_stb & ~ack_q;
    assign wr     = access & bus_we;

    always_comb begin
        rdata = '0;
        case (reg_addr_e'(bus_adr))
            REG_PEND: rdata = 32'(pend_q);
            REG_MASK: rdata = 32'(mask_q);
            REG_MODE: rdata = 32'(mode_q);
            REG_VEC: begin
                rdata     = 32'(cpu_exception_q);
                rdata[31] = irq_valid_q;
            end
            default:  rdata = '0;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mask_d  = mask_q;
        mode_d  = mode_q;
        clr_vec = '0;
        if (wr) begin
            case (reg_addr_e'(bus_adr))
                REG_MASK: mask_d  = bus_dat_i[NSRC-1:0];
                REG_MODE: mode_d  = bus_dat_i[NSRC-1:0];
                REG_CLR:  clr_vec = bus_dat_i[NSRC-1:0];
                default:  ;
            endcase
        end
        ack_d   = access;
        dat_o_d = (access && !bus_we) ? rdata : '0;
    end

    // Edge sources: a new rising edge beats a simultaneous clear. Level sources track the sample.
    always_comb begin
        samp_d = src_in;
        prev_d = samp_q;
        rise   = samp_q & ~prev_q;
        pend_d = (mode_q & (rise | (pend_q & ~clr_vec))) | (~mode_q & samp_q);
    end

    always_comb begin
        act = pend_q & mask_q;
        enc = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act[i]) enc = VECW'(i);
        end
        irq_valid_d     = enabled & (|act);
        cpu_exception_d = irq_valid_d ? enc : cpu_exception_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; the sample and
    // previous-sample registers load the live input in reset so release sees no edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            samp_q          <= irq_in;
            prev_q          <= irq_in;
            pend_q          <= '0;
            mask_q          <= '0;
            mode_q          <= '0;
            ack_q           <= 1'b0;
            dat_o_q         <= '0;
            irq_valid_q     <= 1'b0;
            cpu_exception_q <= '0;
        end else begin
            samp_q          <= samp_d;
            prev_q          <= prev_d;
            pend_q          <= pend_d;
            mask_q          <= mask_d;
            mode_q          <= mode_d;
            ack_q           <= ack_d;
            dat_o_q         <= dat_o_d;
            irq_valid_q     <= irq_valid_d;
            cpu_exception_q <= cpu_exception_d;
        end
    end

    assign bus_ack       = ack_q;
    assign bus_dat_o     = dat_o_q;
    assign irq_valid     = irq_valid_q;
    assign cpu_exception = cpu_exception_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: bus results go through a
// scoreboard queue, interrupt outputs are compared against fixed expectations.
module tb_interrupt_controller;

`ifdef INTC_SYNC_EN
    localparam int IRQ_LAT = 4;
`else
    localparam int IRQ_LAT = 2;
`endif

    logic        clk;
    logic        rst_i;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [2:0]  bus_adr;
    logic [31:0] bus_dat_i;
    logic [31:0] bus_dat_o;
    logic        bus_ack;
    logic [15:0] irq_in;
    logic        enabled;
    logic        irq_valid;
    logic [3:0]  cpu_exception;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic        is_rd;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;

    interrupt_controller #(.NSRC(16), .VECW(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .bus_cyc       (bus_cyc),
        .bus_stb       (bus_stb),
        .bus_we        (bus_we),
        .bus_adr       (bus_adr),
        .bus_dat_i     (bus_dat_i),
        .bus_dat_o     (bus_dat_o),
        .bus_ack       (bus_ack),
        .irq_in        (irq_in),
        .enabled       (enabled),
        .irq_valid     (irq_valid),
        .cpu_exception (cpu_exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: every ack retires the oldest scoreboard entry.
    always @(negedge clk) begin
        if (bus_ack) begin
            if (sb_q.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_rd) check(mon_e.tag, bus_dat_o, mon_e.exp);
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({"ack_", tag}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic bus_start(input logic [2:0] a, input logic w, input logic [31:0] d,
                             input logic [31:0] exp, input string tag);
        sb_t e;
        bus_cyc   = 1'b1;
        bus_stb   = 1'b1;
        bus_we    = w;
        bus_adr   = a;
        bus_dat_i = d;
        e.tag   = tag;
        e.exp   = exp;
        e.is_rd = !w;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus_cyc = 1'b0;
        bus_stb = 1'b0;
        bus_we  = 1'b0;
        drain(tag);
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        @(posedge clk);
        #1;
        bus_start(a, 1'b0, 32'd0, exp, tag);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus_start(a, 1'b1, d, 32'd0, "wr");
    endtask

    task automatic set_irq(input logic [15:0] v);
        @(posedge clk);
        #1;
        irq_in = v;
        repeat (IRQ_LAT + 2) @(negedge clk);
    endtask

    initial begin
        clk       = 1'b0;
        rst_i     = 1'b0;
        bus_cyc   = 1'b0;
        bus_stb   = 1'b0;
        bus_we    = 1'b0;
        bus_adr   = '0;
        bus_dat_i = '0;
        irq_in    = '0;
        enabled   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check("rst_irq_valid", irq_valid, 0);
        check("rst_cpu_exc", cpu_exception, 0);
        check("rst_ack", bus_ack, 0);

        // Reset register map and address/width boundaries.
        for (int a = 0; a < 8; a++) bus_rd(3'(a), 32'd0, "rd_reset");
        bus_wr(3'd1, 32'hFFFF_FFFF);
        bus_rd(3'd1, 32'h0000_FFFF, "mask_width");
        bus_wr(3'd5, 32'hFFFF_FFFF);
        bus_rd(3'd5, 32'd0, "adr5_ignored");
        bus_rd(3'd2, 32'd0, "clr_reads_0");

        // Edge source 2: single-cycle pulse, exact latency, then clear.
        bus_wr(3'd1, 32'h0004);
        bus_wr(3'd3, 32'h0004);
        @(posedge clk);
        #1 irq_in[2] = 1'b1;
        @(posedge clk);
        #1 irq_in[2] = 1'b0;
        repeat (IRQ_LAT) begin
            @(negedge clk);
            check("edge_lat_lo", irq_valid, 0);
        end
        @(negedge clk);
        check("edge_lat_hi", irq_valid, 1);
        check("edge_exc", cpu_exception, 2);
        bus_rd(3'd0, 32'h0004, "pend_edge");
        bus_rd(3'd4, 32'h8000_0002, "vec_edge");
        bus_wr(3'd2, 32'h0004);
        @(negedge clk);
        check("clr_irq_valid", irq_valid, 0);
        bus_rd(3'd0, 32'd0, "pend_cleared");

        // Level priority encoding.
        bus_wr(3'd1, 32'hFFFF);
        bus_wr(3'd3, 32'h0000);
        set_irq(16'h8030);
        check("prio_4", cpu_exception, 4);
        check("prio_valid", irq_valid, 1);
        bus_rd(3'd0, 32'h8030, "pend_level");
        set_irq(16'h8020);
        check("prio_5", cpu_exception, 5);
        set_irq(16'h8000);
        check("prio_15", cpu_exception, 15);
        bus_wr(3'd2, 32'h8000);
        bus_rd(3'd0, 32'h8000, "level_clr_noeffect");
        set_irq(16'h0000);
        check("idle_valid", irq_valid, 0);
        check("idle_exc_hold", cpu_exception, 15);

        // Mode switch keeps pending; set beats a same-edge clear.
        set_irq(16'h0008);
        bus_wr(3'd3, 32'h000A);
        bus_rd(3'd0, 32'h0008, "mode_switch_keep");
        @(posedge clk);
        #1 irq_in = 16'h000A;
        repeat (IRQ_LAT - 1) @(posedge clk);
        #1 bus_start(3'd2, 1'b1, 32'h0002, 32'd0, "clr_vs_set");
        bus_rd(3'd0, 32'h000A, "pend_set_wins");
        bus_wr(3'd2, 32'h0002);
        bus_rd(3'd0, 32'h0008, "pend_edge_clr");
        bus_wr(3'd2, 32'h0008);
        bus_rd(3'd0, 32'h0000, "pend_clr_all");
        check("exc_hold_3", cpu_exception, 3);

        // CPU enable gating.
        @(posedge clk);
        #1 enabled = 1'b0;
        bus_wr(3'd3, 32'h0000);
        set_irq(16'h0100);
        check("dis_valid", irq_valid, 0);
        bus_rd(3'd4, 32'h0000_0003, "vec_disabled");
        bus_rd(3'd0, 32'h0100, "pend_while_disabled");
        @(posedge clk);
        #1 enabled = 1'b1;
        @(negedge clk);
        check("en_valid_lo", irq_valid, 0);
        @(negedge clk);
        check("en_valid_hi", irq_valid, 1);
        check("en_exc", cpu_exception, 8);

        // Reset during a write, sources held high through release.
        @(posedge clk);
        #1;
        irq_in    = 16'hFFFF;
        bus_cyc   = 1'b1;
        bus_stb   = 1'b1;
        bus_we    = 1'b1;
        bus_adr   = 3'd1;
        bus_dat_i = 32'h00FF;
        rst_i     = 1'b0;
        @(posedge clk);
        #1;
        bus_cyc = 1'b0;
        bus_stb = 1'b0;
        bus_we  = 1'b0;
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check("rst2_ack", bus_ack, 0);
        check("rst2_valid", irq_valid, 0);
        check("rst2_exc", cpu_exception, 0);
        bus_rd(3'd1, 32'd0, "write_discarded");
        bus_wr(3'd3, 32'hFFFF);
        bus_wr(3'd1, 32'hFFFF);
        bus_wr(3'd2, 32'hFFFF);
        repeat (IRQ_LAT + 2) @(negedge clk);
        bus_rd(3'd0, 32'd0, "no_spurious_edge");
        check("no_spurious_valid", irq_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
